// File: rtl/expr_eval_if.sv
// Character stream into the evaluator and the evaluated result out of it.
// The master drives characters; the slave (the evaluator) drives results.
interface expr_eval_if #(
  parameter int W = 16
);
  logic [7:0]   in;
  logic [W-1:0] value;
  logic         valid;
  logic         err;
  logic         ovf;

  modport master (output in, input value, valid, err, ovf);
  modport slave  (input in, output value, valid, err, ovf);
endinterface

// File: rtl/expr_eval.sv
// Evaluates digit ((+|*) digit)* on an ASCII stream, one character per clock,
// with * binding tighter than +. Results are registered, one-cycle latency.
module expr_eval #(
  parameter int W = 16
) (
  input  logic        clk,
  input  logic        clr,
  expr_eval_if.slave  bus
);
  localparam logic [2:0] START = 3'd0;
  localparam logic [2:0] NUM   = 3'd1;
  localparam logic [2:0] ADD   = 3'd2;
  localparam logic [2:0] MUL   = 3'd3;
  localparam logic [2:0] ERR   = 3'd4;

  // Declaration initialisers give the reset state at power-up without clr.
  logic [2:0]   state_reg = START;
  logic [W-1:0] sum_reg   = '0;
  logic [W-1:0] term_reg  = '0;
  logic         ovf_reg   = 1'b0;

  logic [2:0]   state_next;
  logic [W-1:0] sum_next;
  logic [W-1:0] term_next;
  logic         ovf_next;

  logic [7:0]   ch;
  logic         is_digit;
  logic         is_add;
  logic         is_mul;
  logic [3:0]   d;
  logic [W:0]   add_full;
  logic [W+3:0] mul_full;
  logic         ovf_out;

  assign ch       = bus.in;
  assign is_digit = (ch >= 8'h30) && (ch <= 8'h39);
  assign is_add   = (ch == 8'h2B);
  assign is_mul   = (ch == 8'h2A);
  assign d        = ch[3:0];

  assign add_full = {1'b0, sum_reg} + {1'b0, term_reg};
  assign mul_full = {4'b0000, term_reg} * {{W{1'b0}}, d};

  // The NUM-state output sum can overflow before any register captures it,
  // so it is folded into the flag combinationally and carried forward.
  assign ovf_out  = ovf_reg | ((state_reg == NUM) & add_full[W]);

  always_comb begin
    state_next = state_reg;
    sum_next   = sum_reg;
    term_next  = term_reg;
    ovf_next   = ovf_out;
    if (!is_digit && !is_add && !is_mul) begin
      state_next = START;
      sum_next   = '0;
      term_next  = '0;
      ovf_next   = 1'b0;
    end else begin
      case (state_reg)
        START: begin
          if (is_digit) begin
            state_next = NUM;
            term_next  = {{(W-4){1'b0}}, d};
            sum_next   = '0;
          end else begin
            state_next = ERR;
          end
        end
        NUM: begin
          if (is_add) begin
            state_next = ADD;
            sum_next   = add_full[W-1:0];
          end else if (is_mul) begin
            state_next = MUL;
          end else begin
            state_next = ERR;
          end
        end
        ADD: begin
          if (is_digit) begin
            state_next = NUM;
            term_next  = {{(W-4){1'b0}}, d};
          end else begin
            state_next = ERR;
          end
        end
        MUL: begin
          if (is_digit) begin
            state_next = NUM;
            term_next  = mul_full[W-1:0];
            ovf_next   = ovf_out | (|mul_full[W+3:W]);
          end else begin
            state_next = ERR;
          end
        end
        ERR: begin
          state_next = ERR;
        end
        default: begin
          state_next = START;
          sum_next   = '0;
          term_next  = '0;
          ovf_next   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg <= START;
      sum_reg   <= '0;
      term_reg  <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      sum_reg   <= sum_next;
      term_reg  <= term_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign bus.valid = (state_reg == NUM);
  assign bus.err   = (state_reg == ERR);
  assign bus.value = (state_reg == NUM) ? add_full[W-1:0] : '0;
  assign bus.ovf   = ovf_out;
endmodule

// File: tb/tb_expr_eval.sv
// Directed vector table, async-reset sequences and a random run against a
// token-level reference model, all with an 8-bit datapath.
module tb_expr_eval;
  localparam int W = 8;
  localparam int MASK = (1 << W) - 1;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  expr_eval_if #(.W(W)) bus ();
  expr_eval #(.W(W)) dut (.clk(clk), .clr(clr), .bus(bus));

  int checks = 0;
  int failures = 0;

  typedef struct {
    byte ch;
    bit  v;
    bit  e;
    bit  o;
    int  val;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input byte ch, input bit v, input bit e, input bit o, input int val);
    vec_t t;
    t.ch = ch; t.v = v; t.e = e; t.o = o; t.val = val;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input bit v, input bit e, input bit o, input int val);
    check({tag, ".valid"}, 32'(bus.valid), 32'(v));
    check({tag, ".err"},   32'(bus.err),   32'(e));
    check({tag, ".ovf"},   32'(bus.ovf),   32'(o));
    check({tag, ".value"}, 32'(bus.value), 32'(val & MASK));
  endtask

  task automatic step(input byte ch);
    bus.in = ch;
    @(posedge clk);
    #1;
    $display("tx ch=%02h valid=%0d err=%0d ovf=%0d value=%0d",
             ch, bus.valid, bus.err, bus.ovf, bus.value);
  endtask

  // Reference model state for the random run.
  bit bad, exp_digit, last_digit, pend_mul, movf;
  longint s_ex, t_ex;
  int ms, mt;

  function automatic longint sat(input longint x);
    return (x > 64'd1000000) ? 64'd1000000 : x;
  endfunction

  task automatic model_sep();
    bad = 0; exp_digit = 1; last_digit = 0; pend_mul = 0; movf = 0;
    s_ex = 0; t_ex = 0; ms = 0; mt = 0;
  endtask

  task automatic model_char(input byte c);
    bit dig, op;
    int dv;
    dig = (c >= 8'h30 && c <= 8'h39);
    op  = (c == 8'h2B || c == 8'h2A);
    dv  = int'(c) - 48;
    if (!dig && !op) begin
      model_sep();
    end else if (!bad) begin
      if (dig != exp_digit) begin
        bad = 1; last_digit = 0;
      end else if (dig) begin
        if (pend_mul) begin
          t_ex = sat(t_ex * dv);
          mt = (mt * dv) & MASK;
        end else begin
          t_ex = dv;
          mt = dv;
        end
        exp_digit = 0; last_digit = 1;
        if (t_ex > MASK || s_ex + t_ex > MASK) movf = 1;
      end else begin
        if (c == 8'h2B) begin
          s_ex = sat(s_ex + t_ex);
          ms = (ms + mt) & MASK;
          pend_mul = 0;
        end else begin
          pend_mul = 1;
        end
        exp_digit = 1; last_digit = 0;
      end
    end
  endtask

  initial begin
    bus.in = " ";
    #3;
    check_all("powerup", 0, 0, 0, 0);

    clr = 1'b1;
    #1;
    check_all("reset", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    clr = 1'b0;

    // Precedence
    add("1", 1, 0, 0, 1);  add("+", 0, 0, 0, 0);  add("2", 1, 0, 0, 3);
    add("*", 0, 0, 0, 0);  add("3", 1, 0, 0, 7);  add(";", 0, 0, 0, 0);
    add("2", 1, 0, 0, 2);  add("*", 0, 0, 0, 0);  add("3", 1, 0, 0, 6);
    add("+", 0, 0, 0, 0);  add("4", 1, 0, 0, 10); add("*", 0, 0, 0, 0);
    add("5", 1, 0, 0, 26); add(";", 0, 0, 0, 0);
    // Errors and separator recovery
    add("1", 1, 0, 0, 1);  add("+", 0, 0, 0, 0);  add("+", 0, 1, 0, 0);
    add("2", 0, 1, 0, 0);  add(";", 0, 0, 0, 0);  add("3", 1, 0, 0, 3);
    add("4", 0, 1, 0, 0);  add(";", 0, 0, 0, 0);  add("*", 0, 1, 0, 0);
    add(";", 0, 0, 0, 0);  add("9", 1, 0, 0, 9);  add("0", 0, 1, 0, 0);
    add(" ", 0, 0, 0, 0);  add("0", 1, 0, 0, 0);  add(" ", 0, 0, 0, 0);
    // Product overflow: 729 mod 256 = 217
    add("9", 1, 0, 0, 9);  add("*", 0, 0, 0, 0);  add("9", 1, 0, 0, 81);
    add("*", 0, 0, 0, 0);  add("9", 1, 0, 1, 217); add("+", 0, 0, 1, 0);
    add(" ", 0, 0, 0, 0);
    // Sum overflow: 81+81+81+9 = 252, +9 = 261 -> 5
    add("9", 1, 0, 0, 9);  add("*", 0, 0, 0, 0);  add("9", 1, 0, 0, 81);
    add("+", 0, 0, 0, 0);  add("9", 1, 0, 0, 90); add("*", 0, 0, 0, 0);
    add("9", 1, 0, 0, 162); add("+", 0, 0, 0, 0); add("9", 1, 0, 0, 171);
    add("*", 0, 0, 0, 0);  add("9", 1, 0, 0, 243); add("+", 0, 0, 0, 0);
    add("9", 1, 0, 0, 252); add("+", 0, 0, 0, 0); add("9", 1, 0, 1, 5);
    add("*", 0, 0, 1, 0);  add("0", 1, 0, 1, 252); add(";", 0, 0, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].ch);
      check_all($sformatf("vec%0d", i), vecs[i].v, vecs[i].e, vecs[i].o, vecs[i].val);
    end

    // Async reset between edges discards "5*"
    step("5");
    step("*");
    #2 clr = 1'b1;
    #1;
    check_all("async_mul", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    step("4");
    check_all("after_clr", 1, 0, 0, 4);

    // Async reset clears a valid value without an edge
    #2 clr = 1'b1;
    #1;
    check_all("async_valid", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    clr = 1'b0;

    // Async reset clears a sticky overflow without an edge
    step("9"); step("*"); step("9"); step("*"); step("9");
    check_all("pre_clr_ovf", 1, 0, 1, 217);
    #2 clr = 1'b1;
    #1;
    check_all("async_ovf", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    clr = 1'b0;

    // Random run against the token model
    model_sep();
    for (int i = 0; i < 300; i++) begin
      int r;
      byte c;
      r = $urandom_range(0, 99);
      if (r < 45)      c = byte'(8'h30 + 8'($urandom_range(0, 9)));
      else if (r < 63) c = "+";
      else if (r < 80) c = "*";
      else if (r < 93) c = ";";
      else             c = "a";
      step(c);
      model_char(c);
      check_all($sformatf("rnd%0d", i), !bad && last_digit, bad, movf,
                (!bad && last_digit) ? ((ms + mt) & MASK) : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
